// File: rtl/mem_sync_top_if.sv
// Bank-side bus of the row-cache synchroniser array.
//   RowId   : row addressed by each bank           [bg][ba][ADDRWIDTH]
//   BankFSM : bank state code per bank             [bg][ba][5]
//   sync    : host acknowledge per bank            [bg][ba]
//   cRowId  : cache slot of current row per bank   [bg][ba][CHWIDTH]
//   stall   : OR of all per-bank allocate-pending flags
// master = bank FSMs / host side, slave = synchroniser array.
interface mem_sync_top_if #(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned CHWIDTH   = 6,
    parameter int unsigned ADDRWIDTH = 17
);
    localparam int unsigned BANKGROUPS    = 2 ** BGWIDTH;
    localparam int unsigned BANKSPERGROUP = 2 ** BAWIDTH;

    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] RowId;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0]           BankFSM;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                sync;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]   cRowId;
    logic                                                    stall;

    modport master (
        output RowId,
        output BankFSM,
        output sync,
        input  cRowId,
        input  stall
    );

    modport slave (
        input  RowId,
        input  BankFSM,
        input  sync,
        output cRowId,
        output stall
    );
endinterface

// File: rtl/mem_sync_top.sv
// Per-bank row-cache synchroniser array.
// One unit per bank maps the open DRAM row to a local cache slot. A miss
// allocates the slot at the round-robin fill pointer and holds stall until the
// host acknowledges the data move with sync.
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous reset, active HIGH despite the name
//   bus     : mem_sync_top_if slave (RowId, BankFSM, sync in; cRowId, stall out)
module mem_sync_top #(
    parameter int unsigned BGWIDTH    = 2,
    parameter int unsigned BANKGROUPS = 4,
    parameter int unsigned BAWIDTH    = 2,
    parameter int unsigned CHWIDTH    = 6,
    parameter int unsigned ADDRWIDTH  = 17
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_sync_top_if.slave  bus
);
    localparam int unsigned BANKSPERGROUP = 2 ** BAWIDTH;
    localparam int unsigned CHROWS        = 2 ** CHWIDTH;

    localparam logic [4:0] CODE_WRITE = 5'b10010;
    localparam logic [4:0] CODE_READ  = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALLOCATE,
        ST_READY
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [ADDRWIDTH-1:0] tag;
    } entry_t;

    // Bank-group count must agree with its address width.
    if (BANKGROUPS != 2 ** BGWIDTH) begin : g_bad_bankgroups
        $error("BANKGROUPS must equal 2**BGWIDTH");
    end

    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0] pend_d;
    logic                                     stall_q;

    for (genvar gi = 0; gi < BANKGROUPS; gi++) begin : g_group
        for (genvar bi = 0; bi < BANKSPERGROUP; bi++) begin : g_unit
            state_t               state_q;
            state_t               state_d;
            logic [CHWIDTH-1:0]   ptr_q;
            logic [CHWIDTH-1:0]   ptr_d;
            logic [CHWIDTH-1:0]   crow_q;
            logic [CHWIDTH-1:0]   crow_d;
            entry_t               table_q [CHROWS];
            logic                 alloc_we;
            logic                 hit;
            logic [CHWIDTH-1:0]   hit_idx;
            logic                 access;
            logic [ADDRWIDTH-1:0] row;
            logic [4:0]           code;
            logic                 ack;

            assign row    = bus.RowId[gi][bi];
            assign code   = bus.BankFSM[gi][bi];
            assign ack    = bus.sync[gi][bi];
            assign access = (code == CODE_WRITE) || (code == CODE_READ);

            // Tag lookup; scanning downward lets the lowest matching slot win.
            always_comb begin
                hit     = 1'b0;
                hit_idx = '0;
                for (int i = int'(CHROWS) - 1; i >= 0; i--) begin
                    if (table_q[CHWIDTH'(i)].valid &&
                        (table_q[CHWIDTH'(i)].tag == row)) begin
                        hit     = 1'b1;
                        hit_idx = CHWIDTH'(i);
                    end
                end
            end

            // Next-state and slot/pointer update.
            always_comb begin
                state_d  = state_q;
                ptr_d    = ptr_q;
                crow_d   = crow_q;
                alloc_we = 1'b0;
                unique case (state_q)
                    ST_IDLE: begin
                        if (access) begin
                            if (hit) begin
                                state_d = ST_READY;
                                crow_d  = hit_idx;
                            end else begin
                                state_d  = ST_ALLOCATE;
                                crow_d   = ptr_q;
                                alloc_we = 1'b1;
                            end
                        end
                    end
                    ST_ALLOCATE: begin
                        // Bank code is deliberately ignored until the host acks.
                        if (ack) begin
                            state_d = ST_READY;
                            ptr_d   = ptr_q + CHWIDTH'(1);
                        end
                    end
                    ST_READY: begin
                        if (!access) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // Unit state, fill pointer, slot register and tag table.
            always_ff @(posedge clk or posedge reset_n) begin
                if (reset_n) begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                    crow_q  <= '0;
                    for (int i = 0; i < int'(CHROWS); i++) begin
                        table_q[CHWIDTH'(i)] <= '0;
                    end
                end else begin
                    state_q <= state_d;
                    ptr_q   <= ptr_d;
                    crow_q  <= crow_d;
                    if (alloc_we) begin
                        table_q[ptr_q] <= '{valid: 1'b1, tag: row};
                    end
                end
            end

            assign pend_d[gi][bi]     = (state_d == ST_ALLOCATE);
            assign bus.cRowId[gi][bi] = crow_q;
        end
    end

    // Stall is registered from the next-state pending flags so it tracks
    // ALLOCATE entry/exit on the same edge as the unit state.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= |pend_d;
        end
    end

    assign bus.stall = stall_q;
endmodule

// File: tb/tb_mem_sync_top.sv
module tb_mem_sync_top;
    localparam int NB      = 16;
    localparam int CHR     = 64;
    localparam int C_WRITE = 18;
    localparam int C_READ  = 11;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mem_sync_top_if #(.BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(6), .ADDRWIDTH(17)) bus ();

    mem_sync_top #(
        .BGWIDTH(2), .BANKGROUPS(4), .BAWIDTH(2), .CHWIDTH(6), .ADDRWIDTH(17)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int fsm_in  [NB];
    int row_in  [NB];
    bit sync_in [NB];

    // Reference model: per-bank slot contents (-1 = empty), fill count, mode.
    int m_mode [NB];   // 0 idle, 1 waiting for host, 2 row open
    int m_crow [NB];
    int m_ptr  [NB];
    int m_tag  [NB][CHR];

    typedef struct {
        int fsm;
        int row;
        bit sync;
        int exp_crow;
        bit exp_stall;
    } vec_t;
    vec_t vt [16];

    function automatic bit is_access(int c);
        return (c == C_WRITE) || (c == C_READ);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_crow(int k);
        return int'(bus.cRowId[k/4][k%4]);
    endfunction

    task automatic apply();
        for (int k = 0; k < NB; k++) begin
            bus.BankFSM[k/4][k%4] = 5'(fsm_in[k]);
            bus.RowId[k/4][k%4]   = 17'(row_in[k]);
            bus.sync[k/4][k%4]    = sync_in[k];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_mode[k] = 0;
            m_crow[k] = 0;
            m_ptr[k]  = 0;
            for (int s = 0; s < CHR; s++) m_tag[k][s] = -1;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NB; k++) begin
            if (m_mode[k] == 0) begin
                if (is_access(fsm_in[k])) begin
                    int found = -1;
                    for (int s = 0; s < CHR; s++)
                        if (found < 0 && m_tag[k][s] == row_in[k]) found = s;
                    if (found >= 0) begin
                        m_mode[k] = 2;
                        m_crow[k] = found;
                    end else begin
                        m_crow[k] = m_ptr[k];
                        m_tag[k][m_ptr[k]] = row_in[k];
                        m_mode[k] = 1;
                    end
                end
            end else if (m_mode[k] == 1) begin
                if (sync_in[k]) begin
                    m_mode[k] = 2;
                    m_ptr[k]  = (m_ptr[k] + 1) % CHR;
                end
            end else begin
                if (!is_access(fsm_in[k])) m_mode[k] = 0;
            end
        end
    endtask

    function automatic int model_stall();
        for (int k = 0; k < NB; k++) if (m_mode[k] == 1) return 1;
        return 0;
    endfunction

    task automatic compare_all();
        for (int k = 0; k < NB; k++)
            check($sformatf("model crow b%0d", k), dut_crow(k), m_crow[k]);
        check("model stall", int'(bus.stall), model_stall());
    endtask

    task automatic tick();
        apply();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_all();
        for (int k = 0; k < NB; k++) begin
            fsm_in[k]  = 0;
            row_in[k]  = 0;
            sync_in[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        apply();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        check("reset stall", int'(bus.stall), 0);
        for (int k = 0; k < NB; k++)
            check($sformatf("reset crow b%0d", k), dut_crow(k), 0);
    endtask

    task automatic set_bank(int k, int code, int row, bit s);
        fsm_in[k]  = code;
        row_in[k]  = row;
        sync_in[k] = s;
    endtask

    // Miss, host ack, release, read back; the slot is checked on miss and hit.
    task automatic write_sync_read(int k, int row, int exp_slot, string tag);
        set_bank(k, C_WRITE, row, 1'b0); tick();
        check({tag, " miss slot"}, dut_crow(k), exp_slot);
        check({tag, " miss stall"}, int'(bus.stall), 1);
        set_bank(k, C_WRITE, row, 1'b1); tick();
        check({tag, " sync stall"}, int'(bus.stall), 0);
        set_bank(k, 0, row, 1'b0); tick();
        set_bank(k, C_READ, row, 1'b0); tick();
        check({tag, " hit slot"}, dut_crow(k), exp_slot);
        check({tag, " hit stall"}, int'(bus.stall), 0);
        set_bank(k, 0, row, 1'b0); tick();
    endtask

    initial begin
        vt[0]  = '{C_WRITE, 'h1234, 1'b0, 0, 1'b1};
        vt[1]  = '{C_WRITE, 'h1234, 1'b1, 0, 1'b0};
        vt[2]  = '{0,       'h1234, 1'b0, 0, 1'b0};
        vt[3]  = '{C_READ,  'h1234, 1'b0, 0, 1'b0};
        vt[4]  = '{0,       'h1234, 1'b0, 0, 1'b0};
        vt[5]  = '{C_WRITE, 'h5555, 1'b0, 1, 1'b1};
        vt[6]  = '{0,       'h0000, 1'b0, 1, 1'b1};
        vt[7]  = '{0,       'h0000, 1'b1, 1, 1'b0};
        vt[8]  = '{0,       'h0000, 1'b0, 1, 1'b0};
        vt[9]  = '{C_READ,  'h1234, 1'b0, 0, 1'b0};
        vt[10] = '{C_READ,  'h1234, 1'b0, 0, 1'b0};
        vt[11] = '{0,       'h1234, 1'b0, 0, 1'b0};
        vt[12] = '{C_READ,  'h5555, 1'b0, 1, 1'b0};
        vt[13] = '{C_READ,  'h5555, 1'b1, 1, 1'b0};
        vt[14] = '{0,       'h5555, 1'b0, 1, 1'b0};
        vt[15] = '{0,       'h5555, 1'b1, 1, 1'b0};

        idle_all();
        model_reset();
        do_reset();

        // Bank (0,0) basic miss/ack/hit table.
        for (int i = 0; i < 16; i++) begin
            set_bank(0, vt[i].fsm, vt[i].row, vt[i].sync);
            tick();
            check($sformatf("vec%0d crow", i), dut_crow(0), vt[i].exp_crow);
            check($sformatf("vec%0d stall", i), int'(bus.stall), int'(vt[i].exp_stall));
        end

        // Every bank allocates its first slot independently.
        do_reset();
        for (int k = 0; k < NB; k++)
            write_sync_read(k, 'h100 + k, 0, $sformatf("sweep b%0d", k));

        // Fill all 64 slots of bank (0,0), then wrap.
        do_reset();
        write_sync_read(0, 'h1234, 0, "fill 0");
        for (int s = 1; s < CHR; s++)
            write_sync_read(0, 'h2000 + s, s, $sformatf("fill %0d", s));
        write_sync_read(0, 'h3000, 0, "wrap");
        set_bank(0, C_READ, 'h1234, 1'b0); tick();
        check("evicted miss slot", dut_crow(0), 1);
        check("evicted miss stall", int'(bus.stall), 1);
        set_bank(0, C_READ, 'h1234, 1'b1); tick();
        set_bank(0, 0, 0, 1'b0); tick();

        // Parallel misses; stall holds until the last bank is acknowledged.
        do_reset();
        set_bank(0, C_WRITE, 'h77, 1'b0);
        set_bank(15, C_READ, 'h88, 1'b0);
        tick();
        check("dual miss stall", int'(bus.stall), 1);
        set_bank(0, C_WRITE, 'h77, 1'b1); tick();
        check("one synced stall", int'(bus.stall), 1);
        set_bank(0, C_WRITE, 'h77, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("other pending stall", int'(bus.stall), 1);
        end
        set_bank(15, C_READ, 'h88, 1'b1); tick();
        check("all synced stall", int'(bus.stall), 0);
        idle_all(); tick();

        // Asynchronous reset during ALLOCATE.
        set_bank(5, C_WRITE, 'h99, 1'b0); tick();
        check("pre-reset stall", int'(bus.stall), 1);
        #2;
        reset_n = 1'b1;
        #1;
        check("async reset stall", int'(bus.stall), 0);
        check("async reset crow b5", dut_crow(5), 0);
        model_reset();
        idle_all();
        apply();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        compare_all();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NB; k++) begin
                int r = int'($urandom_range(0, 3));
                if (r == 0)      fsm_in[k] = C_READ;
                else if (r == 1) fsm_in[k] = C_WRITE;
                else if (r == 2) fsm_in[k] = 0;
                else             fsm_in[k] = int'($urandom_range(0, 31));
                row_in[k]  = int'($urandom_range(0, 79)) + (k % 3) * 256;
                sync_in[k] = ($urandom_range(0, 2) == 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
